spi_sram_bridge: RTL and testbench
==================================

# spi_sram_bridge

Bus slave for the CPU's memory bus that replaces the hard-coded stub responder with an external serial SRAM (23K256-style, SPI mode 0, 16-bit address). It accepts one byte-wide read or write request at a time, translates it into a single SPI frame, and signals completion back to the CPU through a four-phase handshake. The CPU's wait input is `!bus_completed`.

## Interface
- `SCK_HALF`, default 2: SPI clock half-period in `clk` cycles; legal values are 1 to 15.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low; clock clk
- `bus_address_in`  in  16  CPU byte address
- `bus_wdata`  in  8  CPU write data
- `bus_read`  in  1  read request; held by the CPU until `bus_completed` is seen
- `bus_write`  in  1  write request; held by the CPU until `bus_completed` is seen
- `bus_rdata`  out  8  read data; valid while `bus_completed`=1 after a read
- `bus_completed`  out  1  request done; held high until the request drops
- `spi_cs_n`  out  1  chip select, active low
- `spi_sck`  out  1  SPI clock; idles low
- `spi_mosi`  out  1  master out
- `spi_miso`  in  1  master in

## Operation
- **States:**
  - IDLE: waiting for a request.
  - SHIFT_LO: SCK low phase of a bit.
  - SHIFT_HI: SCK high phase of a bit.
  - DONE: `bus_completed`=1.
  - GAP: enforced CS-high interval.
- **IDLE:**
  - A request is `bus_read | bus_write`.
  - If `bus_read` and `bus_write` are high together, the request is a read and the write is ignored.
  - On accept, latch a 32-bit shift register:
    - read: {0x03, addr[15:8], addr[7:0], 0x00}
    - write: {0x02, addr[15:8], addr[7:0], wdata}
  - Also on accept: clear the bit counter (0..31), then go to SHIFT_LO.
- **SHIFT_LO:**
  - `spi_cs_n`=0, `spi_sck`=0, `spi_mosi`=shift[31].
  - After SCK_HALF cycles, go to SHIFT_HI.
- **SHIFT_HI:**
  - `spi_sck`=1.
  - On the last cycle of the phase, sample `spi_miso` into the receive byte (MSB first, bit counter 24..31 only) and shift the shift register left by 1.
  - If the bit counter is 31, go to DONE; otherwise increment the counter and go to SHIFT_LO.
- **DONE:**
  - `spi_cs_n`=1, `spi_sck`=0, `bus_completed`=1.
  - For reads, `bus_rdata` takes the receive byte on DONE entry.
  - Stay in DONE while the request is high; when the request is low, go to GAP.
- **GAP:**
  - `bus_completed`=0, `spi_cs_n`=1.
  - Stay for 2·SCK_HALF cycles counted from CS rise. DONE cycles count toward this total, and GAP lasts at least 1 cycle.
  - Then go to IDLE.
- **Widths and ordering:**
  - Address and data are latched at accept; later changes on the bus inputs are ignored until the next accept.
  - Everything is shifted MSB first.
- **`bus_rdata`:**
  - Changes only at the end of a read.
  - Writes leave it unchanged.
- **Request dropped mid-frame (protocol violation):**
  - The frame completes normally.
  - DONE lasts exactly 1 cycle (`bus_completed` pulses), then the block goes to GAP.
- **Reset (any state, including mid-frame):**
  - At the next edge: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `bus_completed`=0, `bus_rdata`=0x00, state IDLE.
  - Any partial frame is abandoned.

## Timing
- Reset values of all outputs: `bus_rdata`=0x00, `bus_completed`=0, `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0.
- Accept edge t0 is the edge at which the request is sampled high in IDLE.
- At t0+1: `spi_cs_n`=0 and `spi_mosi` = bit 31 (setup of SCK_HALF cycles before the first rising SCK).
- Each bit occupies 2·SCK_HALF cycles:
  - MOSI changes only when SCK falls (or at CS assertion).
  - MISO is sampled at the end of the SCK high phase.
- DONE is entered at t0+1+64·SCK_HALF:
  - `bus_completed`=1, `spi_cs_n`=1 and `bus_rdata` valid, all in the same cycle.
  - Default SCK_HALF=2 gives t0+129.
- Cycle after the request falls: `bus_completed`=0.
- Next accept: no earlier than max(2·SCK_HALF, 2) cycles after `spi_cs_n` rose.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Read, SCK_HALF=2:**
  - Stimulus: read 0x1234, SRAM model returns 0xA5.
  - Required MOSI frame: 0x03, 0x12, 0x34, 0x00.
  - Required: `bus_completed` rises at t0+129 with `bus_rdata`=0xA5; it falls 1 cycle after `bus_read` drops.
- **Write:**
  - Stimulus: write 0x5A to 0xBEEF after a read of 0x3C.
  - Required MOSI frame: 0x02, 0xBE, 0xEF, 0x5A.
  - Required: `bus_rdata` stays 0x3C; the model memory holds 0x5A at 0xBEEF.
- **Back-to-back:**
  - Stimulus: CPU drops the request the cycle after `bus_completed` and re-requests immediately.
  - Required: `spi_cs_n` high for ≥4 cycles between frames; both frames correct.
- **Simultaneous read and write:**
  - Stimulus: `bus_read` and `bus_write` both high at 0x0001.
  - Required: opcode 0x03 sent; the model memory is unchanged.
- **Reset mid-frame:**
  - Stimulus: `rst_n` low at bit 10.
  - Required at the next edge: `spi_cs_n`=1, `spi_sck`=0, `bus_completed`=0, `bus_rdata`=0x00.
  - Required: a subsequent read of 0x0000 succeeds.
- **SCK_HALF=1, reads at 0x0000 and 0xFFFF:**
  - Required: completion at t0+65.
  - Required: the SCK period is 2 cycles.
  - Required: address bytes 0xFF 0xFF are shifted out correctly.

Source files
------------

// File: rtl/spi_sram_bridge_if.sv
// CPU memory-bus signals shared by the CPU (master) and the SPI SRAM bridge (slave).
// Requests are level-held by the CPU; completion uses a four-phase handshake.
interface spi_sram_bridge_if;
   logic [15:0] bus_address_in;
   logic [7:0]  bus_wdata;
   logic        bus_read;
   logic        bus_write;
   logic [7:0]  bus_rdata;
   logic        bus_completed;

   modport master (
      output bus_address_in,
      output bus_wdata,
      output bus_read,
      output bus_write,
      input  bus_rdata,
      input  bus_completed
   );

   modport slave (
      input  bus_address_in,
      input  bus_wdata,
      input  bus_read,
      input  bus_write,
      output bus_rdata,
      output bus_completed
   );
endinterface

// File: rtl/spi_sram_bridge.sv
// Bridges single byte-wide CPU bus requests to a 23K256-style serial SRAM.
// Each request becomes one 32-bit SPI mode-0 frame: opcode, 16-bit address, data byte.
// All outputs come straight from flops; SCK half-period is SCK_HALF clk cycles (1..15).
module spi_sram_bridge #(
   parameter int unsigned SCK_HALF = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_sram_bridge_if.slave bus,
   output logic             spi_cs_n,
   output logic             spi_sck,
   output logic             spi_mosi,
   input  logic             spi_miso
);

   localparam logic [7:0] OpRead       = 8'h03;
   localparam logic [7:0] OpWrite      = 8'h02;
   localparam logic [3:0] HalfLast     = 4'(SCK_HALF - 1);
   // GAP may leave once this many edges beyond the first have passed since CS rose.
   localparam logic [5:0] GapExit      = 6'(2 * SCK_HALF - 2);
   localparam logic [4:0] FirstDataBit = 5'd24;
   localparam logic [4:0] LastBit      = 5'd31;

   typedef enum logic [2:0] {
      StIdle,
      StShiftLo,
      StShiftHi,
      StDone,
      StGap
   } state_e;

   state_e      state_q;
   logic [31:0] shift_q;
   logic [4:0]  bit_cnt_q;
   logic [3:0]  phase_cnt_q;
   logic [5:0]  gap_cnt_q;
   logic        is_read_q;
   logic [7:0]  rx_q;
   logic [7:0]  rdata_q;
   logic        completed_q;

   logic        request;
   logic [31:0] frame;
   logic        phase_end;
   logic [7:0]  rx_next;
   logic [5:0]  gap_next;

   // Request decode and frame assembly for the accept edge; a read wins over a write.
   always_comb begin
      request = bus.bus_read | bus.bus_write;
      if (bus.bus_read) begin
         frame = {OpRead, bus.bus_address_in, 8'h00};
      end else begin
         frame = {OpWrite, bus.bus_address_in, bus.bus_wdata};
      end
      phase_end = (phase_cnt_q == HalfLast);
      rx_next   = {rx_q[6:0], spi_miso};
      gap_next  = (gap_cnt_q == 6'h3f) ? gap_cnt_q : gap_cnt_q + 6'd1;
   end

   // Frame sequencer: accept, shift 32 bits, hold completion, then enforce CS-high time.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         phase_cnt_q <= '0;
         gap_cnt_q   <= '0;
         is_read_q   <= 1'b0;
         rx_q        <= '0;
         rdata_q     <= '0;
         completed_q <= 1'b0;
         spi_cs_n    <= 1'b1;
         spi_sck     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (request) begin
                  is_read_q   <= bus.bus_read;
                  shift_q     <= frame;
                  bit_cnt_q   <= '0;
                  phase_cnt_q <= '0;
                  rx_q        <= '0;
                  spi_cs_n    <= 1'b0;
                  spi_sck     <= 1'b0;
                  state_q     <= StShiftLo;
               end
            end

            StShiftLo: begin
               if (phase_end) begin
                  phase_cnt_q <= '0;
                  spi_sck     <= 1'b1;
                  state_q     <= StShiftHi;
               end else begin
                  phase_cnt_q <= phase_cnt_q + 4'd1;
               end
            end

            StShiftHi: begin
               if (phase_end) begin
                  phase_cnt_q <= '0;
                  // Shifting here makes MOSI change together with the falling SCK.
                  shift_q     <= {shift_q[30:0], 1'b0};
                  spi_sck     <= 1'b0;
                  if (bit_cnt_q >= FirstDataBit) begin
                     rx_q <= rx_next;
                  end
                  if (bit_cnt_q == LastBit) begin
                     spi_cs_n    <= 1'b1;
                     completed_q <= 1'b1;
                     gap_cnt_q   <= '0;
                     if (is_read_q) begin
                        rdata_q <= rx_next;
                     end
                     state_q <= StDone;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     state_q   <= StShiftLo;
                  end
               end else begin
                  phase_cnt_q <= phase_cnt_q + 4'd1;
               end
            end

            StDone: begin
               gap_cnt_q <= gap_next;
               if (!request) begin
                  completed_q <= 1'b0;
                  state_q     <= StGap;
               end
            end

            StGap: begin
               gap_cnt_q <= gap_next;
               if (gap_next > GapExit) begin
                  state_q <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // After 32 shifts (and in reset) the register is all zeros, so MOSI idles low.
   assign spi_mosi          = shift_q[31];
   assign bus.bus_rdata     = rdata_q;
   assign bus.bus_completed = completed_q;

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Directed bench for spi_sram_bridge: SCK_HALF=2 and SCK_HALF=1 instances share one
// behavioural 23K256 model through a selector; only one instance is active at a time.
module tb_spi_sram_bridge;

   logic clk = 1'b0;
   logic rst_n;
   logic sel;
   logic spi_miso = 1'b0;
   logic cs0, sck0, mosi0, cs1, sck1, mosi1;
   logic m_cs_n, m_sck, m_mosi;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_sram_bridge_if bus0 ();
   spi_sram_bridge_if bus1 ();

   spi_sram_bridge #(.SCK_HALF(2)) u_dut0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus0),
      .spi_cs_n (cs0),
      .spi_sck  (sck0),
      .spi_mosi (mosi0),
      .spi_miso (spi_miso)
   );

   spi_sram_bridge #(.SCK_HALF(1)) u_dut1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus1),
      .spi_cs_n (cs1),
      .spi_sck  (sck1),
      .spi_mosi (mosi1),
      .spi_miso (spi_miso)
   );

   assign m_cs_n = sel ? cs1 : cs0;
   assign m_sck  = sel ? sck1 : sck0;
   assign m_mosi = sel ? mosi1 : mosi0;

   // ---------------- serial SRAM model ----------------
   logic [7:0]  mem [0:65535];
   logic [31:0] frame_rx;
   logic [31:0] last_frame = '0;
   logic [7:0]  rd_op;
   logic [15:0] rd_addr;
   int unsigned edge_cnt = 0;
   logic        p_cs = 1'b1;
   logic        p_sck = 1'b0;
   logic [15:0] pre_addr;
   logic [7:0]  pre_data;
   int          pre_req = 0;
   int          p_pre = 0;

   always @(m_cs_n, m_sck, pre_req) begin
      if (pre_req != p_pre) begin
         mem[pre_addr] = pre_data;
         p_pre = pre_req;
      end
      if (p_cs === 1'b1 && m_cs_n === 1'b0) begin
         edge_cnt = 0;
         frame_rx = '0;
         rd_op    = 8'h00;
      end
      if (p_cs === 1'b0 && m_cs_n === 1'b1) begin
         if (edge_cnt == 32) begin
            last_frame = frame_rx;
            if (frame_rx[31:24] == 8'h02) mem[frame_rx[23:8]] = frame_rx[7:0];
         end
         edge_cnt = 0;
         rd_op    = 8'h00;
      end
      if (m_cs_n === 1'b0 && p_sck === 1'b0 && m_sck === 1'b1) begin
         frame_rx = {frame_rx[30:0], m_mosi};
         edge_cnt++;
         if (edge_cnt == 24) begin
            rd_op   = frame_rx[23:16];
            rd_addr = frame_rx[15:0];
         end
      end
      if (m_cs_n === 1'b0 && p_sck === 1'b1 && m_sck === 1'b0) begin
         if (rd_op == 8'h03 && edge_cnt >= 24 && edge_cnt < 32)
            spi_miso = mem[rd_addr][31 - edge_cnt];
      end
      p_cs  = m_cs_n;
      p_sck = m_sck;
   end

   // ---------------- bus-line monitor (sampled mid-cycle) ----------------
   int   cyc = 0;
   int   last_rise = 0;
   int   min_per = 1000;
   int   max_per = 0;
   int   hi_run = 0;
   int   last_hi_run = 0;
   int   mosi_viol = 0;
   logic p2_cs = 1'b1;
   logic p2_sck = 1'b0;
   logic p2_mosi = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (m_cs_n === 1'b1) begin
         hi_run++;
      end else begin
         if (hi_run > 0) last_hi_run = hi_run;
         hi_run = 0;
      end
      if (m_cs_n === 1'b0 && p2_cs === 1'b1) begin
         min_per   = 1000;
         max_per   = 0;
         last_rise = 0;
      end
      if (m_cs_n === 1'b0 && m_sck === 1'b1 && p2_sck === 1'b0) begin
         if (last_rise != 0) begin
            if (cyc - last_rise < min_per) min_per = cyc - last_rise;
            if (cyc - last_rise > max_per) max_per = cyc - last_rise;
         end
         last_rise = cyc;
      end
      if (m_cs_n === 1'b0 && p2_cs === 1'b0 && m_mosi !== p2_mosi &&
          !(p2_sck === 1'b1 && m_sck === 1'b0))
         mosi_viol++;
      p2_cs   = m_cs_n;
      p2_sck  = m_sck;
      p2_mosi = m_mosi;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic cur_completed();
      return sel ? bus1.bus_completed : bus0.bus_completed;
   endfunction

   function automatic logic [7:0] cur_rdata();
      return sel ? bus1.bus_rdata : bus0.bus_rdata;
   endfunction

   task automatic drive_req(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [7:0] wd);
      if (sel) begin
         bus1.bus_read = rd; bus1.bus_write = wr;
         bus1.bus_address_in = addr; bus1.bus_wdata = wd;
      end else begin
         bus0.bus_read = rd; bus0.bus_write = wr;
         bus0.bus_address_in = addr; bus0.bus_wdata = wd;
      end
   endtask

   task automatic preload(input logic [15:0] addr, input logic [7:0] data);
      pre_addr = addr;
      pre_data = data;
      pre_req++;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One CPU transaction; CPU drops the request at the first cycle it sees completion.
   task automatic do_xfer(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [7:0] wd, input bit immediate,
                          output int lat, output logic timed_out, output logic cs_at1,
                          output logic mosi_at1, output logic [7:0] rdata_done,
                          output logic comp_after);
      if (!immediate) @(negedge clk);
      drive_req(rd, wr, addr, wd);
      @(posedge clk);
      lat = 0; timed_out = 1'b0; cs_at1 = 1'b1; mosi_at1 = 1'b1;
      while (1) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            cs_at1   = m_cs_n;
            mosi_at1 = m_mosi;
         end
         if (cur_completed() === 1'b1) break;
         if (lat >= 2000) begin
            timed_out = 1'b1;
            break;
         end
      end
      rdata_done = cur_rdata();
      drive_req(1'b0, 1'b0, addr, wd);
      @(negedge clk);
      comp_after = cur_completed();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_checks++; if (cs0 !== 1'b1) begin n_fail++; $display("FAIL rst_cs0: got %b want 1", cs0); end
      n_checks++; if (sck0 !== 1'b0) begin n_fail++; $display("FAIL rst_sck0: got %b want 0", sck0); end
      n_checks++; if (mosi0 !== 1'b0) begin n_fail++; $display("FAIL rst_mosi0: got %b want 0", mosi0); end
      n_checks++; if (bus0.bus_completed !== 1'b0) begin n_fail++; $display("FAIL rst_comp0: got %b want 0", bus0.bus_completed); end
      n_checks++; if (bus0.bus_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata0: got %h want 00", bus0.bus_rdata); end
      n_checks++; if (cs1 !== 1'b1) begin n_fail++; $display("FAIL rst_cs1: got %b want 1", cs1); end
      n_checks++; if (sck1 !== 1'b0) begin n_fail++; $display("FAIL rst_sck1: got %b want 0", sck1); end
      n_checks++; if (mosi1 !== 1'b0) begin n_fail++; $display("FAIL rst_mosi1: got %b want 0", mosi1); end
      n_checks++; if (bus1.bus_completed !== 1'b0) begin n_fail++; $display("FAIL rst_comp1: got %b want 0", bus1.bus_completed); end
      n_checks++; if (bus1.bus_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata1: got %h want 00", bus1.bus_rdata); end
   endtask

   task automatic test_read();
      int lat; logic to, c1, m1, ca; logic [7:0] rd;
      preload(16'h1234, 8'hA5);
      idle(4);
      do_xfer(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, lat, to, c1, m1, rd, ca);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL read_timeout: got %b want 0", to); end
      n_checks++; if (c1 !== 1'b0) begin n_fail++; $display("FAIL read_cs_t1: got %b want 0", c1); end
      n_checks++; if (m1 !== 1'b0) begin n_fail++; $display("FAIL read_mosi_t1: got %b want 0", m1); end
      n_checks++; if (lat != 129) begin n_fail++; $display("FAIL read_latency: got %0d want 129", lat); end
      n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL read_rdata: got %h want a5", rd); end
      n_checks++; if (ca !== 1'b0) begin n_fail++; $display("FAIL read_comp_fall: got %b want 0", ca); end
      n_checks++; if (last_frame !== 32'h0312_3400) begin n_fail++; $display("FAIL read_frame: got %h want 03123400", last_frame); end
      n_checks++; if (min_per != 4 || max_per != 4) begin n_fail++; $display("FAIL read_sck_period: got %0d..%0d want 4..4", min_per, max_per); end
   endtask

   task automatic test_write();
      int lat; logic to, c1, m1, ca; logic [7:0] rd;
      preload(16'h4321, 8'h3C);
      idle(8);
      do_xfer(1'b1, 1'b0, 16'h4321, 8'h00, 1'b0, lat, to, c1, m1, rd, ca);
      n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL wr_pre_read: got %h want 3c", rd); end
      idle(8);
      do_xfer(1'b0, 1'b1, 16'hBEEF, 8'h5A, 1'b0, lat, to, c1, m1, rd, ca);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL wr_timeout: got %b want 0", to); end
      n_checks++; if (last_frame !== 32'h02BE_EF5A) begin n_fail++; $display("FAIL wr_frame: got %h want 02beef5a", last_frame); end
      n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want 3c", rd); end
      n_checks++; if (bus0.bus_rdata !== 8'h3C) begin n_fail++; $display("FAIL wr_rdata_after: got %h want 3c", bus0.bus_rdata); end
      n_checks++; if (mem[16'hBEEF] !== 8'h5A) begin n_fail++; $display("FAIL wr_mem: got %h want 5a", mem[16'hBEEF]); end
   endtask

   task automatic test_back_to_back();
      int lat; logic to, c1, m1, ca; logic [7:0] rd;
      idle(8);
      do_xfer(1'b0, 1'b1, 16'h1111, 8'h99, 1'b0, lat, to, c1, m1, rd, ca);
      n_checks++; if (last_frame !== 32'h0211_1199) begin n_fail++; $display("FAIL b2b_frame1: got %h want 02111199", last_frame); end
      do_xfer(1'b1, 1'b0, 16'h1111, 8'h00, 1'b1, lat, to, c1, m1, rd, ca);
      n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %b want 0", to); end
      n_checks++; if (last_frame !== 32'h0311_1100) begin n_fail++; $display("FAIL b2b_frame2: got %h want 03111100", last_frame); end
      n_checks++; if (rd !== 8'h99) begin n_fail++; $display("FAIL b2b_rdata: got %h want 99", rd); end
      n_checks++; if (last_hi_run < 4) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d cycles want >=4", last_hi_run); end
   endtask

   task automatic test_simultaneous();
      int lat; logic to, c1, m1, ca; logic [7:0] rd;
      preload(16'h0001, 8'h11);
      idle(8);
      do_xfer(1'b1, 1'b1, 16'h0001, 8'hEE, 1'b0, lat, to, c1, m1, rd, ca);
      n_checks++; if (last_frame !== 32'h0300_0100) begin n_fail++; $display("FAIL sim_frame: got %h want 03000100", last_frame); end
      n_checks++; if (mem[16'h0001] !== 8'h11) begin n_fail++; $display("FAIL sim_mem: got %h want 11", mem[16'h0001]); end
      n_checks++; if (rd !== 8'h11) begin n_fail++; $display("FAIL sim_rdata: got %h want 11", rd); end
   endtask

   task automatic test_reset_mid_frame();
      int lat; int waited; logic to, c1, m1, ca; logic [7:0] rd;
      preload(16'h0000, 8'h77);
      idle(8);
      drive_req(1'b1, 1'b0, 16'h2222, 8'h00);
      waited = 0;
      while (edge_cnt < 10 && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      n_checks++; if (edge_cnt != 10) begin n_fail++; $display("FAIL mid_reach_bit10: got %0d want 10", edge_cnt); end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++; if (cs0 !== 1'b1) begin n_fail++; $display("FAIL mid_cs: got %b want 1", cs0); end
      n_checks++; if (sck0 !== 1'b0) begin n_fail++; $display("FAIL mid_sck: got %b want 0", sck0); end
      n_checks++; if (mosi0 !== 1'b0) begin n_fail++; $display("FAIL mid_mosi: got %b want 0", mosi0); end
      n_checks++; if (bus0.bus_completed !== 1'b0) begin n_fail++; $display("FAIL mid_comp: got %b want 0", bus0.bus_completed); end
      n_checks++; if (bus0.bus_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_rdata: got %h want 00", bus0.bus_rdata); end
      drive_req(1'b0, 1'b0, 16'h0000, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      do_xfer(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, lat, to, c1, m1, rd, ca);
      n_checks++; if (lat != 129) begin n_fail++; $display("FAIL mid_after_latency: got %0d want 129", lat); end
      n_checks++; if (rd !== 8'h77) begin n_fail++; $display("FAIL mid_after_rdata: got %h want 77", rd); end
      n_checks++; if (last_frame !== 32'h0300_0000) begin n_fail++; $display("FAIL mid_after_frame: got %h want 03000000", last_frame); end
   endtask

   task automatic test_fast_sck();
      int lat; logic to, c1, m1, ca; logic [7:0] rd;
      preload(16'hFFFF, 8'hC3);
      idle(8);
      sel = 1'b1;
      idle(2);
      do_xfer(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, lat, to, c1, m1, rd, ca);
      n_checks++; if (lat != 65) begin n_fail++; $display("FAIL fast_lat_0000: got %0d want 65", lat); end
      n_checks++; if (rd !== 8'h77) begin n_fail++; $display("FAIL fast_rdata_0000: got %h want 77", rd); end
      n_checks++; if (min_per != 2 || max_per != 2) begin n_fail++; $display("FAIL fast_sck_period: got %0d..%0d want 2..2", min_per, max_per); end
      idle(6);
      do_xfer(1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, lat, to, c1, m1, rd, ca);
      n_checks++; if (lat != 65) begin n_fail++; $display("FAIL fast_lat_ffff: got %0d want 65", lat); end
      n_checks++; if (last_frame !== 32'h03FF_FF00) begin n_fail++; $display("FAIL fast_frame_ffff: got %h want 03ffff00", last_frame); end
      n_checks++; if (rd !== 8'hC3) begin n_fail++; $display("FAIL fast_rdata_ffff: got %h want c3", rd); end
      n_checks++; if (ca !== 1'b0) begin n_fail++; $display("FAIL fast_comp_fall: got %b want 0", ca); end
   endtask

   initial begin
      sel   = 1'b0;
      rst_n = 1'b0;
      bus0.bus_read = 1'b0; bus0.bus_write = 1'b0; bus0.bus_address_in = '0; bus0.bus_wdata = '0;
      bus1.bus_read = 1'b0; bus1.bus_write = 1'b0; bus1.bus_address_in = '0; bus1.bus_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_read();
      test_write();
      test_back_to_back();
      test_simultaneous();
      test_reset_mid_frame();
      test_fast_sck();
      n_checks++; if (mosi_viol != 0) begin n_fail++; $display("FAIL mosi_timing: got %0d changes outside SCK fall want 0", mosi_viol); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
